pipelined_control_unit: RTL and testbench

Registered, flow-controlled successor to the combinational instruction decoder. It sits between fetch and execute and accepts one 9-bit instruction per cycle over a valid/ready handshake. Each accepted instruction produces a registered control word. The block also owns the branch flags, stalls conditional branches until outstanding compares resolve, squashes wrong-path slots after a taken branch, and latches a HALT state.

---
 rtl/ctrl_pkg.sv | 62 ++++++
 rtl/ctrl_decode.sv | 90 +++++++++
 rtl/pipelined_control_unit.sv | 159 +++++++++++++++
 tb/tb_pipelined_control_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and encodings for the pipelined control unit
package ctrl_pkg;

    typedef enum logic [1:0] {
        ITYPE_R = 2'b00,
        ITYPE_M = 2'b01,
        ITYPE_B = 2'b10,
        ITYPE_S = 2'b11
    } instruction_type;

    localparam logic [3:0] FUNCT_AND  = 4'd0;
    localparam logic [3:0] FUNCT_OR   = 4'd1;
    localparam logic [3:0] FUNCT_XOR  = 4'd2;
    localparam logic [3:0] FUNCT_ADD  = 4'd3;
    localparam logic [3:0] FUNCT_SUB  = 4'd4;
    localparam logic [3:0] FUNCT_SLT  = 4'd5;
    localparam logic [3:0] FUNCT_SLTE = 4'd6;
    localparam logic [3:0] FUNCT_EQ   = 4'd7;

    localparam logic [2:0] MOP_STORE      = 3'd0;
    localparam logic [2:0] MOP_LOAD       = 3'd1;
    localparam logic [2:0] MOP_LUT_LO     = 3'd2;
    localparam logic [2:0] MOP_LUT_HI     = 3'd3;
    localparam logic [2:0] MOP_LUT_WR0    = 3'd4;
    localparam logic [2:0] MOP_LUT_WR1    = 3'd5;
    localparam logic [2:0] MOP_LUT_TO_REG = 3'd6;
    localparam logic [2:0] MOP_HALT       = 3'd7;

    localparam logic [1:0] BC_EQ     = 2'd0;
    localparam logic [1:0] BC_LT     = 2'd1;
    localparam logic [1:0] BC_LE     = 2'd2;
    localparam logic [1:0] BC_ALWAYS = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } ctrl_state_t;

    // Wide fields are sized for the largest supported LUT_W/SHAMT_W; the top slices them down.
    localparam int CW_W = 32;

    typedef struct packed {
        logic [2:0]      alu_op;
        logic            reg_to_reg;
        logic            mem_to_reg;
        logic            reg_to_mem;
        logic            shift_en;
        logic            shift_dir;
        logic            shift_imm_en;
        logic [CW_W-1:0] shift_imm;
        logic            lut_write;
        logic [CW_W-1:0] lut_index;
        logic            lut_to_reg;
        logic [1:0]      lut_to_reg_idx;
        logic            branch_en;
        logic [CW_W-1:0] branch_target;
        logic            is_compare;
        logic            illegal;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational instruction decode into a control word
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int LUT_W = 8
) (
    input  logic [8:0]       instr,
    input  logic             flag_eq,
    input  logic             flag_lt,
    input  logic [LUT_W-1:0] idx_q,
    output ctrl_word_t       word,
    output logic [LUT_W-1:0] idx_d,
    output logic             is_cond_branch,
    output logic             is_compare,
    output logic             is_halt
);

    logic taken;

    always_comb begin
        word           = '0;
        idx_d          = idx_q;
        is_cond_branch = 1'b0;
        is_compare     = 1'b0;
        is_halt        = 1'b0;
        taken          = 1'b0;
        case (instruction_type'(instr[8:7]))
            ITYPE_R: begin
                if (instr[3:0] <= FUNCT_SUB) begin
                    word.alu_op     = instr[6:4];
                    word.reg_to_reg = 1'b1;
                end else if (instr[3:0] <= FUNCT_EQ) begin
                    word.alu_op     = instr[6:4];
                    word.is_compare = 1'b1;
                    is_compare      = 1'b1;
                end else begin
                    word.illegal = 1'b1;
                end
            end
            ITYPE_M: begin
                case (instr[6:4])
                    MOP_STORE: word.reg_to_mem = 1'b1;
                    MOP_LOAD:  word.mem_to_reg = 1'b1;
                    MOP_LUT_LO: begin
                        idx_d[3:0]     = instr[3:0];
                        word.lut_write = 1'b1;
                        word.lut_index = CW_W'(idx_d);
                    end
                    MOP_LUT_HI: begin
                        idx_d[LUT_W-1:4] = (LUT_W-4)'(instr[3:0]);
                        word.lut_write   = 1'b1;
                        word.lut_index   = CW_W'(idx_d);
                    end
                    MOP_LUT_WR0, MOP_LUT_WR1: begin
                        word.lut_write = 1'b1;
                        word.lut_index = CW_W'(instr[3:0]);
                    end
                    MOP_LUT_TO_REG: begin
                        word.lut_to_reg     = 1'b1;
                        word.lut_to_reg_idx = instr[3:2];
                    end
                    default: is_halt = 1'b1;
                endcase
            end
            ITYPE_B: begin
                is_cond_branch = (instr[6:5] != BC_ALWAYS);
                case (instr[6:5])
                    BC_EQ:   taken = flag_eq;
                    BC_LT:   taken = flag_lt;
                    BC_LE:   taken = flag_eq | flag_lt;
                    default: taken = 1'b1;
                endcase
                if (taken) begin
                    word.branch_en     = 1'b1;
                    word.branch_target = CW_W'(instr[4:0]);
                end
            end
            default: begin
                word.shift_en   = 1'b1;
                word.reg_to_reg = 1'b1;
                word.shift_dir  = instr[5];
                if (instr[6]) begin
                    word.shift_imm_en = 1'b1;
                    word.shift_imm    = CW_W'(instr[4:0]);
                end
            end
        endcase
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - handshake, compare tracking, flush/halt FSM and output register
module pipelined_control_unit
    import ctrl_pkg::*;
#(
    parameter int LUT_W       = 8,
    parameter int SHAMT_W     = 8,
    parameter int FLUSH_DEPTH = 1,
    parameter int MAX_PEND    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [8:0]         instr,
    input  logic               cmp_valid,
    input  logic               cmp_equal,
    input  logic               cmp_less,
    output logic               out_valid,
    output logic [2:0]         alu_op,
    output logic               reg_to_reg,
    output logic               mem_to_reg,
    output logic               reg_to_mem,
    output logic               shift_en,
    output logic               shift_dir,
    output logic               shift_imm_en,
    output logic [SHAMT_W-1:0] shift_imm,
    output logic               lut_write,
    output logic [LUT_W-1:0]   lut_index,
    output logic               lut_to_reg,
    output logic [1:0]         lut_to_reg_idx,
    output logic               branch_en,
    output logic [LUT_W-1:0]   branch_target,
    output logic               is_compare,
    output logic               illegal,
    output logic               halted
);

    localparam int                PEND_W     = $clog2(MAX_PEND + 1);
    localparam logic [PEND_W-1:0] PEND_MAX   = PEND_W'(MAX_PEND);
    localparam logic [3:0]        FLUSH_LOAD = 4'((FLUSH_DEPTH > 0) ? FLUSH_DEPTH - 1 : 0);

    ctrl_state_t       state_q, state_d;
    logic [3:0]        flush_cnt_q, flush_cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              flag_eq_q, flag_eq_d;
    logic              flag_lt_q, flag_lt_d;
    logic [LUT_W-1:0]  idx_q, idx_d;
    logic              out_valid_q, out_valid_d;
    ctrl_word_t        word_q, word_d;

    ctrl_word_t        dec_word;
    logic [LUT_W-1:0]  dec_idx;
    logic              dec_cond, dec_cmp, dec_halt;
    logic              accept;
    logic              unused_word;

    ctrl_decode #(.LUT_W(LUT_W)) u_decode (
        .instr          (instr),
        .flag_eq        (flag_eq_q),
        .flag_lt        (flag_lt_q),
        .idx_q          (idx_q),
        .word           (dec_word),
        .idx_d          (dec_idx),
        .is_cond_branch (dec_cond),
        .is_compare     (dec_cmp),
        .is_halt        (dec_halt)
    );

    assign instr_ready = !reset && (state_q == ST_RUN)
                         && !(dec_cond && (pend_q != '0))
                         && !(dec_cmp && (pend_q == PEND_MAX));
    assign accept = instr_valid && instr_ready;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        pend_d      = pend_q;
        flag_eq_d   = flag_eq_q;
        flag_lt_d   = flag_lt_q;
        idx_d       = idx_q;
        out_valid_d = accept;
        word_d      = '0;
        if (accept) begin
            word_d = dec_word;
            idx_d  = dec_idx;
        end
        if (cmp_valid) begin
            flag_eq_d = cmp_equal;
            flag_lt_d = cmp_less;
        end
        // A result arriving with nothing outstanding only refreshes the flags.
        case ({accept && dec_cmp, cmp_valid && (pend_q != '0)})
            2'b10:   pend_d = pend_q + 1'b1;
            2'b01:   pend_d = pend_q - 1'b1;
            default: pend_d = pend_q;
        endcase
        case (state_q)
            ST_RUN: begin
                if (accept && dec_halt) begin
                    state_d = ST_HALT;
                end else if (accept && dec_word.branch_en && (FLUSH_DEPTH > 0)) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
            pend_q      <= '0;
            flag_eq_q   <= 1'b0;
            flag_lt_q   <= 1'b0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            word_q      <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            pend_q      <= pend_d;
            flag_eq_q   <= flag_eq_d;
            flag_lt_q   <= flag_lt_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            word_q      <= word_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign alu_op         = word_q.alu_op;
    assign reg_to_reg     = word_q.reg_to_reg;
    assign mem_to_reg     = word_q.mem_to_reg;
    assign reg_to_mem     = word_q.reg_to_mem;
    assign shift_en       = word_q.shift_en;
    assign shift_dir      = word_q.shift_dir;
    assign shift_imm_en   = word_q.shift_imm_en;
    assign shift_imm      = word_q.shift_imm[SHAMT_W-1:0];
    assign lut_write      = word_q.lut_write;
    assign lut_index      = word_q.lut_index[LUT_W-1:0];
    assign lut_to_reg     = word_q.lut_to_reg;
    assign lut_to_reg_idx = word_q.lut_to_reg_idx;
    assign branch_en      = word_q.branch_en;
    assign branch_target  = word_q.branch_target[LUT_W-1:0];
    assign is_compare     = word_q.is_compare;
    assign illegal        = word_q.illegal;
    assign halted         = (state_q == ST_HALT);
    assign unused_word    = ^word_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb/tb_pipelined_control_unit.sv - directed bench with a behavioural reference model
module tb_pipelined_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic [8:0] instr = '0;
    logic       cmp_valid = 1'b0, cmp_equal = 1'b0, cmp_less = 1'b0;
    logic       instr_ready, out_valid, reg_to_reg, mem_to_reg, reg_to_mem;
    logic       shift_en, shift_dir, shift_imm_en, lut_write, lut_to_reg;
    logic       branch_en, is_compare, illegal, halted;
    logic [2:0] alu_op;
    logic [7:0] shift_imm, lut_index, branch_target;
    logic [1:0] lut_to_reg_idx;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int          m_pend, m_idx, m_flush;
    bit          m_eq, m_lt, m_halt;
    bit          exp_ready;
    logic [41:0] exp_vec;
    logic [41:0] dut_vec;

    always #5 clk = ~clk;

    pipelined_control_unit dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .cmp_valid(cmp_valid), .cmp_equal(cmp_equal), .cmp_less(cmp_less),
        .out_valid(out_valid), .alu_op(alu_op), .reg_to_reg(reg_to_reg),
        .mem_to_reg(mem_to_reg), .reg_to_mem(reg_to_mem), .shift_en(shift_en),
        .shift_dir(shift_dir), .shift_imm_en(shift_imm_en), .shift_imm(shift_imm),
        .lut_write(lut_write), .lut_index(lut_index), .lut_to_reg(lut_to_reg),
        .lut_to_reg_idx(lut_to_reg_idx), .branch_en(branch_en), .branch_target(branch_target),
        .is_compare(is_compare), .illegal(illegal), .halted(halted)
    );

    assign dut_vec = {out_valid, alu_op, reg_to_reg, mem_to_reg, reg_to_mem, shift_en,
                      shift_dir, shift_imm_en, shift_imm, lut_write, lut_index, lut_to_reg,
                      lut_to_reg_idx, branch_en, branch_target, is_compare, illegal, halted};

    // What an accepted instruction must produce, given the current flags and index value.
    task automatic model_dec(input logic [8:0] ins, input bit eq, input bit lt, input int idx_in,
                             output logic [40:0] vec, output int idx_out, output bit taken,
                             output bit iscmp, output bit ishalt, output bit iscond);
        logic [2:0] alu;
        logic [7:0] simm, li, bt;
        logic [1:0] l2ri;
        bit r2r, m2r, r2m, se, sd, sie, lw, l2r, be, il;
        int f, sub, cond;
        alu = '0; simm = '0; li = '0; bt = '0; l2ri = '0;
        r2r = 0; m2r = 0; r2m = 0; se = 0; sd = 0; sie = 0; lw = 0; l2r = 0; be = 0; il = 0;
        taken = 0; iscmp = 0; ishalt = 0; iscond = 0;
        idx_out = idx_in;
        f = int'(ins[3:0]);
        sub = int'(ins[6:4]);
        cond = int'(ins[6:5]);
        case (ins[8:7])
            2'b00: begin
                if (f < 8) begin
                    alu = ins[6:4];
                    if (f < 5) r2r = 1; else iscmp = 1;
                end else il = 1;
            end
            2'b01: begin
                case (sub)
                    0: r2m = 1;
                    1: m2r = 1;
                    2: begin idx_out = (idx_in / 16) * 16 + f; lw = 1; li = 8'(idx_out); end
                    3: begin idx_out = f * 16 + idx_in % 16; lw = 1; li = 8'(idx_out); end
                    4, 5: begin lw = 1; li = 8'(f); end
                    6: begin l2r = 1; l2ri = ins[3:2]; end
                    default: ishalt = 1;
                endcase
            end
            2'b10: begin
                taken = (cond == 3) || (cond == 0 && eq) || (cond == 1 && lt)
                        || (cond == 2 && (eq || lt));
                iscond = (cond != 3);
                if (taken) begin be = 1; bt = 8'(ins[4:0]); end
            end
            default: begin
                se = 1; r2r = 1; sd = ins[5];
                if (ins[6]) begin sie = 1; simm = 8'(ins[4:0]); end
            end
        endcase
        vec = {1'b1, alu, r2r, m2r, r2m, se, sd, sie, simm, lw, li, l2r, l2ri, be, bt, iscmp, il};
    endtask

    task automatic setin(input bit rst, input bit v, input logic [8:0] ins,
                         input bit cv, input bit ce, input bit cl);
        logic [40:0] vec;
        int ni;
        bit tk, ic, ih, icb;
        reset = rst; instr_valid = v; instr = ins;
        cmp_valid = cv; cmp_equal = ce; cmp_less = cl;
        model_dec(ins, m_eq, m_lt, m_idx, vec, ni, tk, ic, ih, icb);
        exp_ready = !rst && !m_halt && (m_flush == 0) && !(icb && m_pend > 0) && !(ic && m_pend == 3);
    endtask

    task automatic tick();
        logic [40:0] vec;
        int ni, p;
        bit tk, ic, ih, icb, acc;
        @(posedge clk);
        if (reset) begin
            m_pend = 0; m_idx = 0; m_flush = 0; m_eq = 0; m_lt = 0; m_halt = 0;
            exp_vec = '0;
        end else begin
            model_dec(instr, m_eq, m_lt, m_idx, vec, ni, tk, ic, ih, icb);
            acc = instr_valid && exp_ready;
            p = m_pend;
            if (m_flush > 0) m_flush--;
            else if (acc && tk) m_flush = 1;
            if (acc && ic) m_pend++;
            if (cmp_valid && p > 0) m_pend--;
            if (cmp_valid) begin m_eq = cmp_equal; m_lt = cmp_less; end
            if (acc) begin
                m_idx = ni;
                m_halt = m_halt | ih;
                exp_vec = {vec, m_halt};
            end else begin
                exp_vec = {41'b0, m_halt};
            end
        end
        #1;
    endtask

    task automatic cyc(input bit rst, input bit v, input logic [8:0] ins,
                       input bit cv, input bit ce, input bit cl);
        setin(rst, v, ins, cv, ce, cl);
        tick();
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (instr_ready !== exp_ready) begin
                errors++;
                $display("FAIL ready got %b expected %b at %0t", instr_ready, exp_ready, $time);
            end
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL outputs got %h expected %h at %0t", dut_vec, exp_vec, $time);
            end
        end
    end

    initial begin
        cyc(1, 0, 9'h0, 0, 0, 0);
        cyc(1, 0, 9'h0, 0, 0, 0);
        chk_en = 1'b1;
        lit("reset_out_valid", 32'(out_valid), 0);
        lit("reset_halted", 32'(halted), 0);

        cyc(0, 1, 9'b00_011_0011, 0, 0, 0);
        lit("add_valid", 32'(out_valid), 1);
        lit("add_alu", 32'(alu_op), 3);
        lit("add_r2r", 32'(reg_to_reg), 1);
        cyc(0, 0, 9'h0, 0, 0, 0);
        lit("idle_valid", 32'(out_valid), 0);

        cyc(0, 1, 9'b00_000_0111, 0, 0, 0);
        lit("eq_is_compare", 32'(is_compare), 1);
        setin(0, 1, 9'b10_00_00101, 0, 0, 0); #1;
        lit("beq_stall0", 32'(instr_ready), 0); tick();
        setin(0, 1, 9'b10_00_00101, 1, 1, 0); #1;
        lit("beq_stall1", 32'(instr_ready), 0); tick();
        setin(0, 1, 9'b10_00_00101, 0, 0, 0); #1;
        lit("beq_ready", 32'(instr_ready), 1); tick();
        lit("beq_taken", 32'(branch_en), 1);
        lit("beq_target", 32'(branch_target), 32'h05);
        setin(0, 0, 9'h0, 0, 0, 0); #1;
        lit("flush_ready", 32'(instr_ready), 0); tick();
        setin(0, 0, 9'h0, 0, 0, 0); #1;
        lit("post_flush_ready", 32'(instr_ready), 1); tick();

        cyc(0, 1, 9'b10_01_00011, 0, 0, 0);
        lit("blt_valid", 32'(out_valid), 1);
        lit("blt_not_taken", 32'(branch_en), 0);
        setin(0, 0, 9'h0, 0, 0, 0); #1;
        lit("blt_no_flush", 32'(instr_ready), 1); tick();

        cyc(0, 1, 9'b01_010_0011, 0, 0, 0);
        lit("lut_lo", 32'(lut_index), 32'h03);
        cyc(0, 1, 9'b01_011_1010, 0, 0, 0);
        lit("lut_hi", 32'(lut_index), 32'hA3);
        cyc(0, 1, 9'b01_100_0101, 0, 0, 0);
        lit("lut_direct", 32'(lut_index), 32'h05);
        cyc(0, 1, 9'b01_010_1111, 0, 0, 0);
        lit("lut_lo_keeps_hi", 32'(lut_index), 32'hAF);
        cyc(0, 1, 9'b11_11_10110, 0, 0, 0);
        lit("rsi_imm", 32'(shift_imm), 32'h16);
        lit("rsi_dir", 32'(shift_dir), 1);
        cyc(0, 1, 9'b00_111_1000, 0, 0, 0);
        lit("illegal_flag", 32'(illegal), 1);
        lit("illegal_alu", 32'(alu_op), 0);

        for (int k = 0; k < 3; k++) cyc(0, 1, 9'b00_000_0101, 0, 0, 0);
        setin(0, 1, 9'b00_000_0101, 0, 0, 0); #1;
        lit("fourth_cmp_stall", 32'(instr_ready), 0); tick();
        setin(0, 1, 9'b00_000_0101, 1, 0, 0); #1;
        lit("fourth_cmp_stall_cv", 32'(instr_ready), 0); tick();
        setin(0, 1, 9'b00_000_0101, 0, 0, 0); #1;
        lit("fourth_cmp_ready", 32'(instr_ready), 1); tick();
        lit("fourth_cmp_out", 32'(is_compare), 1);
        for (int k = 0; k < 3; k++) cyc(0, 0, 9'h0, 1, 0, 1);

        for (int i = 0; i < 512; i++) begin
            logic [8:0] iv;
            iv = 9'(i);
            if (iv[8:4] == 5'b01111) cyc(0, 0, iv, 1, iv[1], iv[2]);
            else cyc(0, 1, iv, (i % 3) == 0, iv[1], iv[2]);
        end
        cyc(0, 0, 9'h0, 0, 0, 0);
        cyc(0, 0, 9'h0, 0, 0, 0);

        cyc(0, 1, 9'b10_11_00001, 0, 0, 0);
        lit("always_taken", 32'(branch_en), 1);
        cyc(1, 0, 9'h0, 0, 0, 0);
        lit("rst_flush_branch", 32'(branch_en), 0);
        setin(0, 0, 9'h0, 0, 0, 0); #1;
        lit("rst_flush_ready", 32'(instr_ready), 1); tick();

        cyc(0, 1, 9'b01_111_0000, 0, 0, 0);
        lit("halt_valid", 32'(out_valid), 1);
        lit("halt_flag", 32'(halted), 1);
        for (int k = 0; k < 20; k++) begin
            setin(0, 1, 9'b00_011_0011, 0, 0, 0); #1;
            lit("halt_ready", 32'(instr_ready), 0); tick();
        end
        lit("halt_held", 32'(halted), 1);
        cyc(1, 0, 9'h0, 0, 0, 0);
        lit("rst_halt_halted", 32'(halted), 0);
        setin(0, 1, 9'b00_011_0011, 0, 0, 0); #1;
        lit("rst_halt_ready", 32'(instr_ready), 1); tick();
        lit("post_halt_alu", 32'(alu_op), 3);
        cyc(0, 0, 9'h0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
